// File: rtl/tl_ul_link_pkg.sv
// ---------------------------------------------------------------------------
// tl_ul_link_pkg
// Shared TileLink-UL beat layouts and constants for the link buffer.
//   - tl_a_beat_t / tl_d_beat_t : packed beat layouts (MSB first) at the
//     default widths (SRC_W=5, ADDR_W=32, DATA_W=32).
//   - A_W / D_W                 : packed widths of those beats (84 / 48).
//   - TL_* opcodes              : A-channel and D-channel opcode values.
// ---------------------------------------------------------------------------
package tl_ul_link_pkg;

    localparam int TL_SRC_W  = 5;
    localparam int TL_ADDR_W = 32;
    localparam int TL_DATA_W = 32;
    localparam int TL_MASK_W = TL_DATA_W / 8;

    localparam int A_W = 3 + 3 + 4 + TL_SRC_W + TL_ADDR_W + TL_MASK_W + TL_DATA_W + 1;
    localparam int D_W = 3 + 2 + 4 + TL_SRC_W + 1 + TL_DATA_W + 1;

    // A-channel opcodes
    localparam logic [2:0] TL_GET         = 3'd4;
    localparam logic [2:0] TL_PUT_FULL    = 3'd0;
    localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
    // D-channel opcodes
    localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

    typedef struct packed {
        logic [2:0]           opcode;
        logic [2:0]           param;
        logic [3:0]           size;
        logic [TL_SRC_W-1:0]  source;
        logic [TL_ADDR_W-1:0] address;
        logic [TL_MASK_W-1:0] mask;
        logic [TL_DATA_W-1:0] data;
        logic                 corrupt;
    } tl_a_beat_t;

    typedef struct packed {
        logic [2:0]           opcode;
        logic [1:0]           param;
        logic [3:0]           size;
        logic [TL_SRC_W-1:0]  source;
        logic                 denied;
        logic [TL_DATA_W-1:0] data;
        logic                 corrupt;
    } tl_d_beat_t;

endpackage

// File: rtl/tl_buf_fifo.sv
// ---------------------------------------------------------------------------
// tl_buf_fifo
// Registered DEPTH-entry FIFO used for one TileLink channel.
// Handshake: a beat transfers on a side in any cycle where valid && ready.
// in_ready and out_valid depend only on the registered count, so there is no
// combinational path from out_ready to in_ready and no enq->out bypass.
// Ports:
//   clock, reset            clock, asynchronous active-high reset
//   in_valid/in_ready/in_bits     upstream handshake + payload
//   out_valid/out_ready/out_bits  downstream handshake + head payload
//   count                   current occupancy (0..DEPTH)
// ---------------------------------------------------------------------------
module tl_buf_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_bits,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_bits,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             enq;
    logic             deq;

    // Full blocks enqueue even if a dequeue happens in the same cycle.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign enq       = in_valid && in_ready;
    assign deq       = out_valid && out_ready;
    assign out_bits  = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (deq) rd_ptr <= rd_ptr + PW'(1);
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage is intentionally not reset.
    always_ff @(posedge clock) begin
        if (enq) mem[wr_ptr] <= in_bits;
    end

endmodule

// File: rtl/tl_ul_link_buffer.sv
// ---------------------------------------------------------------------------
// tl_ul_link_buffer
// Two-channel TileLink-UL link buffer: an A-channel FIFO (master->slave) and
// an independent D-channel FIFO (slave->master), both fully registered.
// Optional in-flight source tracking is compiled in with the macro
// TL_UL_LINK_BUFFER_INFLIGHT_EN; otherwise inflight_cnt/inflight_err are 0.
// Ports:
//   clock, reset                          clock, async active-high reset
//   a_in_valid/a_in_ready/a_in_bits       upstream A handshake
//   a_out_valid/a_out_ready/a_out_bits    downstream A handshake
//   d_in_valid/d_in_ready/d_in_bits       D handshake from slave
//   d_out_valid/d_out_ready/d_out_bits    D handshake to master
//   a_count, d_count                      FIFO occupancy
//   inflight_cnt                          outstanding source IDs
//   inflight_err                          sticky source-tracking error
// ---------------------------------------------------------------------------
module tl_ul_link_buffer
    import tl_ul_link_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int SRC_W  = 5,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                                           clock,
    input  logic                                           reset,
    input  logic                                           a_in_valid,
    output logic                                           a_in_ready,
    input  logic [3+3+4+SRC_W+ADDR_W+DATA_W/8+DATA_W+1-1:0] a_in_bits,
    output logic                                           a_out_valid,
    input  logic                                           a_out_ready,
    output logic [3+3+4+SRC_W+ADDR_W+DATA_W/8+DATA_W+1-1:0] a_out_bits,
    input  logic                                           d_in_valid,
    output logic                                           d_in_ready,
    input  logic [3+2+4+SRC_W+1+DATA_W+1-1:0]              d_in_bits,
    output logic                                           d_out_valid,
    input  logic                                           d_out_ready,
    output logic [3+2+4+SRC_W+1+DATA_W+1-1:0]              d_out_bits,
    output logic [$clog2(DEPTH):0]                         a_count,
    output logic [$clog2(DEPTH):0]                         d_count,
    output logic [SRC_W:0]                                 inflight_cnt,
    output logic                                           inflight_err
);

    localparam int AW = 3 + 3 + 4 + SRC_W + ADDR_W + DATA_W/8 + DATA_W + 1;
    localparam int DW = 3 + 2 + 4 + SRC_W + 1 + DATA_W + 1;

    tl_buf_fifo #(.WIDTH(AW), .DEPTH(DEPTH)) u_a_fifo (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_bits   (a_in_bits),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_bits  (a_out_bits),
        .count     (a_count)
    );

    tl_buf_fifo #(.WIDTH(DW), .DEPTH(DEPTH)) u_d_fifo (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (d_in_valid),
        .in_ready  (d_in_ready),
        .in_bits   (d_in_bits),
        .out_valid (d_out_valid),
        .out_ready (d_out_ready),
        .out_bits  (d_out_bits),
        .count     (d_count)
    );

`ifdef TL_UL_LINK_BUFFER_INFLIGHT_EN
    // Source field offsets inside the packed beats (LSB of the field).
    localparam int A_SRC_LSB = ADDR_W + DATA_W/8 + DATA_W + 1;
    localparam int D_SRC_LSB = 1 + DATA_W + 1;

    logic [(2**SRC_W)-1:0] pend;
    logic [(2**SRC_W)-1:0] pend_nxt;
    logic [SRC_W-1:0]      a_src;
    logic [SRC_W-1:0]      d_src;
    logic                  a_deq;
    logic                  d_deq;
    logic                  inc;
    logic                  dec;
    logic                  err_set;

    // Tracking is done on the outgoing side of each FIFO: a request counts as
    // in flight once it has left toward the slave, and retires once its
    // response has been handed to the master.
    assign a_src = a_out_bits[A_SRC_LSB +: SRC_W];
    assign d_src = d_out_bits[D_SRC_LSB +: SRC_W];
    assign a_deq = a_out_valid && a_out_ready;
    assign d_deq = d_out_valid && d_out_ready;

    always_comb begin
        pend_nxt = pend;
        inc      = 1'b0;
        dec      = 1'b0;
        err_set  = 1'b0;
        if (a_deq && d_deq && (a_src == d_src)) begin
            // Same source on both channels: whichever op changes the bit wins.
            if (pend[a_src]) begin
                pend_nxt[a_src] = 1'b0;
                dec             = 1'b1;
            end else begin
                pend_nxt[a_src] = 1'b1;
                inc             = 1'b1;
            end
        end else begin
            if (a_deq) begin
                if (pend[a_src]) begin
                    err_set = 1'b1;
                end else begin
                    pend_nxt[a_src] = 1'b1;
                    inc             = 1'b1;
                end
            end
            if (d_deq) begin
                if (!pend[d_src]) begin
                    err_set = 1'b1;
                end else begin
                    pend_nxt[d_src] = 1'b0;
                    dec             = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend         <= '0;
            inflight_cnt <= '0;
            inflight_err <= 1'b0;
        end else begin
            pend <= pend_nxt;
            case ({inc, dec})
                2'b10:   inflight_cnt <= inflight_cnt + (SRC_W+1)'(1);
                2'b01:   inflight_cnt <= inflight_cnt - (SRC_W+1)'(1);
                default: inflight_cnt <= inflight_cnt;
            endcase
            if (err_set) inflight_err <= 1'b1;
        end
    end
`else
    assign inflight_cnt = '0;
    assign inflight_err = 1'b0;
`endif

endmodule

// File: doc/tl_ul_link_buffer.md
Name: tl_ul_link_buffer

Overview:
- Registered two-channel TileLink-UL link buffer: A-channel (master->slave requests) and D-channel (slave->master responses), each with an independent DEPTH-entry FIFO.
- Drives the link observed by the TL protocol monitor; sits between the core-side TL master port and the AXI4 bridge.
- Breaks all valid/ready timing paths.
- Optionally tracks in-flight source IDs and raises a sticky error.

Parameters:
- DEPTH, 2, entries per channel FIFO; power of two, >=2.
- SRC_W, 5, source ID width.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; mask width = DATA_W/8.

Ports:
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- a_in_valid / a_in_ready  in / out  1 / 1  upstream A handshake.
- a_in_bits  in  A_W (84)  packed {opcode[3], param[3], size[4], source[SRC_W], address[ADDR_W], mask[DATA_W/8], data[DATA_W], corrupt[1]}.
- a_out_valid / a_out_ready  out / in  1 / 1  downstream A handshake.
- a_out_bits  out  A_W  FIFO head payload.
- d_in_valid / d_in_ready  in / out  1 / 1  downstream D handshake (from slave).
- d_in_bits  in  D_W (48)  packed {opcode[3], param[2], size[4], source[SRC_W], denied[1], data[DATA_W], corrupt[1]}.
- d_out_valid / d_out_ready  out / in  1 / 1  upstream D handshake (to master).
- d_out_bits  out  D_W  FIFO head payload.
- a_count, d_count  out  $clog2(DEPTH)+1 each  current occupancy.
- inflight_cnt  out  SRC_W+1  outstanding requests (0 when feature compiled out).
- inflight_err  out  1  sticky protocol error (0 when feature compiled out).

Behaviour:
- Reset: all pointers and counts = 0; *_out_valid = 0; *_in_ready = 1 after reset releases; inflight_cnt = 0; inflight_err = 0; payload storage is not reset.
- Reset asserted mid-operation: every entry is discarded immediately (asynchronous); no partial beat is replayed.
- Enqueue on in_valid && in_ready; dequeue on out_valid && out_ready.
- in_ready = !full, driven from registered count only. No combinational path from out_ready to in_ready.
- out_valid = !empty, from register. out_bits is driven from the storage array at the read pointer.
- Latency: a beat enqueued in cycle N is visible at out in cycle N+1 at the earliest. Throughput is 1 beat/cycle per channel with DEPTH >= 2.
- Simultaneous enq+deq when neither full nor empty: count is unchanged and both pointers advance.
- Full: in_ready = 0, so no enqueue, even if a dequeue occurs in the same cycle. The slot frees next cycle.
- Empty: out_valid = 0 and out_bits are don't-care. A same-cycle enq does not bypass to the output.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count range is 0..DEPTH.
- Channels are fully independent, with no ordering between A and D.
- Payload is passed bit-exact and unchanged.

Optional Feature:
- Macro: TL_UL_LINK_BUFFER_INFLIGHT_EN.
- Enabled:
  - 2^SRC_W-bit pending bitmap.
  - On A dequeue, set bit[source]. If the bit is already set, inflight_err <= 1.
  - On D dequeue, clear bit[source]. If the bit is clear, inflight_err <= 1.
  - Same-cycle A and D on the same source with the bit clear: the set wins and no error is raised.
  - Same-cycle A and D on the same source with the bit set: the clear wins and no error is raised.
  - inflight_cnt = popcount-equivalent counter, updated +1/-1/0.
  - inflight_err clears only on reset.
- Disabled: no bitmap logic is generated; inflight_cnt and inflight_err are tied to 0.

Decomposition:
- Package tl_ul_link_pkg holds:
  - Packed struct typedefs tl_a_beat_t and tl_d_beat_t.
  - Localparams A_W and D_W.
  - Opcode constants: Get=4, PutFull=0, PutPartial=1, AccessAck=0, AccessAckData=1.
- Sub-module tl_buf_fifo #(WIDTH, DEPTH) holds the storage, pointers, count and ready/valid. It is instantiated once per channel.

Test Plan:
- Reset release, no traffic -> a_in_ready=d_in_ready=1, a_out_valid=d_out_valid=0, counts 0, inflight_err=0.
- Push Get address 0x8000_0040, source 3; a_out_ready=1 -> beat appears on a_out in the next cycle, bit-exact; a_count goes 1 then 0.
- a_out_ready=0, push 3 beats with DEPTH=2 -> a_in_ready falls after the 2nd beat and the 3rd is held. Release ready -> beats emerge in order, 1/cycle.
- Continuous enq+deq for 10 cycles at count=1 -> count stays 1, 10 beats out in order; check pointer wrap.
- Assert reset with a_count=2 -> a_out_valid=0 and a_count=0 immediately, before the next clock edge.
- INFLIGHT_EN, exercised one case per run:
  - A source 5 twice without D -> inflight_err=1, stays set.
  - D source 7 with nothing outstanding -> inflight_err=1.
  - A/D paired traffic on sources 0..31 -> inflight_cnt returns to 0 and inflight_err=0.
